// File: rtl/sistema_ram_arbiter.sv
// sistema_ram_arbiter: shares one single-port synchronous RAM between two
// Avalon-style requesters (m0, m1). Grants are combinational, reads return
// with a fixed one-cycle latency, writes complete in their grant cycle.
// Optional build macro SISTEMA_RAM_ARB_FIXED_PRIO_EN selects fixed priority
// (m0 always wins); when undefined, the arbiter is round-robin.
module sistema_ram_arbiter #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned BE_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  // requester 0
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  // requester 1
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  // RAM side
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } ram_req_t;

  logic     req0;
  logic     req1;
  logic     gnt_valid;
  logic     gnt_idx;
  logic     gnt_write;
  ram_req_t m0_req;
  ram_req_t m1_req;
  ram_req_t gnt_req;
  ram_req_t hold_q;
  logic     rd_pending_q;
  logic     rd_owner_q;
`ifndef SISTEMA_RAM_ARB_FIXED_PRIO_EN
  logic     last_grant_q;
`endif

  assign req0   = m0_read | m0_write;
  assign req1   = m1_read | m1_write;
  assign m0_req = '{addr: m0_address, be: m0_byteenable, wdata: m0_writedata};
  assign m1_req = '{addr: m1_address, be: m1_byteenable, wdata: m1_writedata};

  // Arbitration: pick at most one requester this cycle; nothing is granted in reset.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = 1'b0;
    if (!reset) begin
      if (req0 && req1) begin
        gnt_valid = 1'b1;
`ifdef SISTEMA_RAM_ARB_FIXED_PRIO_EN
        gnt_idx   = 1'b0;
`else
        gnt_idx   = ~last_grant_q;
`endif
      end else if (req0) begin
        gnt_valid = 1'b1;
        gnt_idx   = 1'b0;
      end else if (req1) begin
        gnt_valid = 1'b1;
        gnt_idx   = 1'b1;
      end
    end
  end

  // RAM-side mux: granted requester's payload, otherwise the held last grant.
  always_comb begin
    gnt_req   = hold_q;
    gnt_write = 1'b0;
    if (gnt_valid) begin
      gnt_req   = gnt_idx ? m1_req : m0_req;
      gnt_write = gnt_idx ? m1_write : m0_write;
    end
  end

  assign ram_address    = gnt_req.addr;
  assign ram_byteenable = gnt_req.be;
  assign ram_writedata  = gnt_req.wdata;
  assign ram_chipselect = gnt_valid;
  assign ram_write      = gnt_write;
  assign ram_clken      = 1'b1;

  // Stall any requester that asks but loses; everyone stalls while in reset.
  assign m0_waitrequest = reset | (req0 & ~(gnt_valid & ~gnt_idx));
  assign m1_waitrequest = reset | (req1 & ~(gnt_valid &  gnt_idx));

  // Return path: RAM data one cycle after a read grant, zero otherwise.
  assign m0_readdatavalid = rd_pending_q & ~rd_owner_q;
  assign m1_readdatavalid = rd_pending_q &  rd_owner_q;
  assign m0_readdata      = m0_readdatavalid ? ram_readdata : '0;
  assign m1_readdata      = m1_readdatavalid ? ram_readdata : '0;

  // Hold register and in-flight read tracking; reset drops any pending read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q       <= '0;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      rd_pending_q <= gnt_valid & ~gnt_write;
      if (gnt_valid) begin
        hold_q <= gnt_req;
      end
      if (gnt_valid && !gnt_write) begin
        rd_owner_q <= gnt_idx;
      end
    end
  end

`ifndef SISTEMA_RAM_ARB_FIXED_PRIO_EN
  // Round-robin history: remembers the last winner, so m0 wins first after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else if (gnt_valid) begin
      last_grant_q <= gnt_idx;
    end
  end
`endif

endmodule

// File: tb/tb_sistema_ram_arbiter.sv
// Bench for sistema_ram_arbiter: directed vector table, reset corner
// sequences, then randomized traffic against a rule-level reference model.
module tb_sistema_ram_arbiter;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned NV     = 14;
  localparam int unsigned NRAND  = 400;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] m0_address, m1_address;
  logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
  logic              m0_read, m0_write, m1_read, m1_write;
  logic [DATA_W-1:0] m0_writedata, m1_writedata;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0] ram_address;
  logic [BE_W-1:0]   ram_byteenable;
  logic              ram_chipselect, ram_write, ram_clken;
  logic [DATA_W-1:0] ram_writedata;
  logic [DATA_W-1:0] ram_readdata;

  sistema_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_clken(ram_clken), .ram_readdata(ram_readdata)
  );

  always #5 clk = ~clk;

  // Synchronous byte-lane RAM: preload, then one access per clock.
  logic [DATA_W-1:0] mem [DEPTH];
  initial begin
    for (int k = 0; k < int'(DEPTH); k++) mem[k] = 32'hA500_0000 | 32'(k);
    mem[10'h3FF] = 32'hAAAA_AAAA;
    forever begin
      @(posedge clk);
      if (ram_clken && ram_chipselect) begin
        if (ram_write) begin
          for (int b = 0; b < int'(BE_W); b++)
            if (ram_byteenable[b]) mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
        end
        ram_readdata <= mem[ram_address];
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r0, w0, input logic [ADDR_W-1:0] a0, input logic [BE_W-1:0] be0,
                       input logic [DATA_W-1:0] d0, input logic r1, w1, input logic [ADDR_W-1:0] a1,
                       input logic [BE_W-1:0] be1, input logic [DATA_W-1:0] d1);
    m0_read = r0; m0_write = w0; m0_address = a0; m0_byteenable = be0; m0_writedata = d0;
    m1_read = r1; m1_write = w1; m1_address = a1; m1_byteenable = be1; m1_writedata = d1;
  endtask

  task automatic idle();
    drive(L, L, '0, '0, '0, L, L, '0, '0, '0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk_bit({tag, "_wait0"}, m0_waitrequest, H);
    chk_bit({tag, "_wait1"}, m1_waitrequest, H);
    chk_bit({tag, "_cs"}, ram_chipselect, L);
    chk_bit({tag, "_we"}, ram_write, L);
    chk_word({tag, "_addr"}, 32'(ram_address), 32'h0);
    chk_word({tag, "_be"}, 32'(ram_byteenable), 32'h0);
    chk_word({tag, "_wdata"}, ram_writedata, 32'h0);
    chk_bit({tag, "_rdv0"}, m0_readdatavalid, L);
    chk_bit({tag, "_rdv1"}, m1_readdatavalid, L);
    chk_word({tag, "_rd0"}, m0_readdata, 32'h0);
    chk_word({tag, "_rd1"}, m1_readdata, 32'h0);
    chk_bit({tag, "_clken"}, ram_clken, H);
  endtask

  typedef struct {
    logic r0, w0; logic [ADDR_W-1:0] a0; logic [BE_W-1:0] be0; logic [DATA_W-1:0] d0;
    logic r1, w1; logic [ADDR_W-1:0] a1; logic [BE_W-1:0] be1; logic [DATA_W-1:0] d1;
    logic xw0, xw1, xcs, xwe; logic [ADDR_W-1:0] xa;
    logic xv0, xv1; logic [DATA_W-1:0] xd;
  } vec_t;

  function automatic vec_t mk(
    input logic r0, w0, input logic [ADDR_W-1:0] a0, input logic [BE_W-1:0] be0, input logic [DATA_W-1:0] d0,
    input logic r1, w1, input logic [ADDR_W-1:0] a1, input logic [BE_W-1:0] be1, input logic [DATA_W-1:0] d1,
    input logic xw0, xw1, xcs, xwe, input logic [ADDR_W-1:0] xa,
    input logic xv0, xv1, input logic [DATA_W-1:0] xd);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.be0 = be0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.be1 = be1; v.d1 = d1;
    v.xw0 = xw0; v.xw1 = xw1; v.xcs = xcs; v.xwe = xwe; v.xa = xa;
    v.xv0 = xv0; v.xv1 = xv1; v.xd = xd;
    return v;
  endfunction

  typedef struct { logic owner; logic [DATA_W-1:0] data; } ret_t;

  vec_t              vec [NV];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  ret_t              retq [$];

  initial begin : main
    logic [DATA_W-1:0] d;
    logic              rq [2];
    logic              r [2], w [2], hold [2];
    logic [ADDR_W-1:0] a [2];
    logic [BE_W-1:0]   be [2];
    logic [DATA_W-1:0] wd [2];
    logic [ADDR_W-1:0] last_a;
    logic [BE_W-1:0]   last_be;
    logic [DATA_W-1:0] last_d;
    logic              xv0, xv1;
    logic [DATA_W-1:0] xd0, xd1;
    int                prev_w, win, kind;
    ret_t              ret;

    // Contention reads right after reset: m0 first, then alternation.
    vec[0] = mk(H,L,10'h010,4'hF,32'h0, H,L,10'h020,4'hF,32'h0, L,H,H,L,10'h010, L,L,32'h0);
`ifdef SISTEMA_RAM_ARB_FIXED_PRIO_EN
    vec[1] = mk(H,L,10'h010,4'hF,32'h0, H,L,10'h020,4'hF,32'h0, L,H,H,L,10'h010, H,L,32'hA500_0010);
    vec[2] = mk(H,L,10'h010,4'hF,32'h0, H,L,10'h020,4'hF,32'h0, L,H,H,L,10'h010, H,L,32'hA500_0010);
    vec[3] = mk(H,L,10'h010,4'hF,32'h0, H,L,10'h020,4'hF,32'h0, L,H,H,L,10'h010, H,L,32'hA500_0010);
    vec[4] = mk(L,L,10'h000,4'h0,32'h0, L,L,10'h000,4'h0,32'h0, L,L,L,L,10'h010, H,L,32'hA500_0010);
`else
    vec[1] = mk(H,L,10'h010,4'hF,32'h0, H,L,10'h020,4'hF,32'h0, H,L,H,L,10'h020, H,L,32'hA500_0010);
    vec[2] = mk(H,L,10'h010,4'hF,32'h0, H,L,10'h020,4'hF,32'h0, L,H,H,L,10'h010, L,H,32'hA500_0020);
    vec[3] = mk(H,L,10'h010,4'hF,32'h0, H,L,10'h020,4'hF,32'h0, H,L,H,L,10'h020, H,L,32'hA500_0010);
    vec[4] = mk(L,L,10'h000,4'h0,32'h0, L,L,10'h000,4'h0,32'h0, L,L,L,L,10'h020, L,H,32'hA500_0020);
`endif
    // m0 write then read back.
    vec[5]  = mk(L,H,10'h005,4'hF,32'hDEAD_BEEF, L,L,10'h000,4'h0,32'h0, L,L,H,H,10'h005, L,L,32'h0);
    vec[6]  = mk(H,L,10'h005,4'hF,32'h0, L,L,10'h000,4'h0,32'h0, L,L,H,L,10'h005, L,L,32'h0);
    vec[7]  = mk(L,L,10'h000,4'h0,32'h0, L,L,10'h000,4'h0,32'h0, L,L,L,L,10'h005, H,L,32'hDEAD_BEEF);
    // m1 partial write at the top address, then read back.
    vec[8]  = mk(L,L,10'h000,4'h0,32'h0, L,H,10'h3FF,4'h3,32'h1122_3344, L,L,H,H,10'h3FF, L,L,32'h0);
    vec[9]  = mk(L,L,10'h000,4'h0,32'h0, H,L,10'h3FF,4'hF,32'h0, L,L,H,L,10'h3FF, L,L,32'h0);
    vec[10] = mk(L,L,10'h000,4'h0,32'h0, L,L,10'h000,4'h0,32'h0, L,L,L,L,10'h3FF, L,H,32'hAAAA_3344);
    // read+write together acts as write only.
    vec[11] = mk(H,H,10'h001,4'hF,32'h5A5A_5A5A, L,L,10'h000,4'h0,32'h0, L,L,H,H,10'h001, L,L,32'h0);
    vec[12] = mk(H,L,10'h001,4'hF,32'h0, L,L,10'h000,4'h0,32'h0, L,L,H,L,10'h001, L,L,32'h0);
    vec[13] = mk(L,L,10'h000,4'h0,32'h0, L,L,10'h000,4'h0,32'h0, L,L,L,L,10'h001, H,L,32'h5A5A_5A5A);

    // Reset state, with requests present to show they are stalled.
    reset = 1'b1;
    idle();
    @(negedge clk);
    chk_reset_outs("rst_idle");
    drive(H, L, 10'h010, 4'hF, '0, L, H, 10'h020, 4'hF, 32'h1234_5678);
    @(negedge clk);
    chk_reset_outs("rst_req");
    idle();
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed vector table.
    for (int i = 0; i < int'(NV); i++) begin
      drive(vec[i].r0, vec[i].w0, vec[i].a0, vec[i].be0, vec[i].d0,
            vec[i].r1, vec[i].w1, vec[i].a1, vec[i].be1, vec[i].d1);
      @(negedge clk);
      chk_bit($sformatf("v%0d_wait0", i), m0_waitrequest, vec[i].xw0);
      chk_bit($sformatf("v%0d_wait1", i), m1_waitrequest, vec[i].xw1);
      chk_bit($sformatf("v%0d_cs", i), ram_chipselect, vec[i].xcs);
      chk_bit($sformatf("v%0d_we", i), ram_write, vec[i].xwe);
      chk_word($sformatf("v%0d_addr", i), 32'(ram_address), 32'(vec[i].xa));
      chk_bit($sformatf("v%0d_rdv0", i), m0_readdatavalid, vec[i].xv0);
      chk_bit($sformatf("v%0d_rdv1", i), m1_readdatavalid, vec[i].xv1);
      chk_word($sformatf("v%0d_rd0", i), m0_readdata, vec[i].xv0 ? vec[i].xd : 32'h0);
      chk_word($sformatf("v%0d_rd1", i), m1_readdata, vec[i].xv1 ? vec[i].xd : 32'h0);
      @(posedge clk); #1;
    end

    // Read granted, then reset lands before the data-return edge.
    drive(H, L, 10'h010, 4'hF, '0, L, L, '0, '0, '0);
    @(negedge clk);
    chk_bit("rr_grant_wait0", m0_waitrequest, L);
    chk_bit("rr_grant_cs", ram_chipselect, H);
    reset = 1'b1;
    #1;
    chk_reset_outs("rr_in_reset");
    idle();
    @(negedge clk);
    chk_bit("rr_hold_rdv0", m0_readdatavalid, L);
    reset = 1'b0;
    @(posedge clk); #1;
    // First cycle after release: both request, m0 must win, no stale data.
    drive(H, L, 10'h030, 4'hF, '0, H, L, 10'h040, 4'hF, '0);
    @(negedge clk);
    chk_bit("post_rst_rdv0", m0_readdatavalid, L);
    chk_bit("post_rst_rdv1", m1_readdatavalid, L);
    chk_bit("post_rst_wait0", m0_waitrequest, L);
    chk_bit("post_rst_wait1", m1_waitrequest, H);
    chk_word("post_rst_addr", 32'(ram_address), 32'h030);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk_bit("post_rst_rdv0_new", m0_readdatavalid, H);
    chk_word("post_rst_rd0_new", m0_readdata, 32'hA500_0030);

    // Clean start for the randomized phase.
    reset = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < int'(DEPTH); k++) ref_mem[k] = mem[k];
    reset = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;

    prev_w = 1;
    last_a = '0; last_be = '0; last_d = '0;
    hold[0] = 1'b0; hold[1] = 1'b0;
    for (int n = 0; n < 2; n++) begin
      r[n] = 1'b0; w[n] = 1'b0; a[n] = '0; be[n] = '0; wd[n] = '0;
    end
    for (int c = 0; c < int'(NRAND); c++) begin
      // A stalled requester keeps its request unchanged.
      for (int n = 0; n < 2; n++) begin
        if (!hold[n]) begin
          kind  = int'($urandom_range(0, 9));
          r[n]  = (kind >= 3 && kind <= 6) || kind == 9;
          w[n]  = (kind >= 7);
          a[n]  = ADDR_W'($urandom_range(0, 15));
          be[n] = BE_W'($urandom);
          wd[n] = DATA_W'($urandom);
        end
      end
      drive(r[0], w[0], a[0], be[0], wd[0], r[1], w[1], a[1], be[1], wd[1]);
      @(negedge clk);

      rq[0] = r[0] | w[0];
      rq[1] = r[1] | w[1];
      win = -1;
      if (rq[0] && rq[1]) begin
`ifdef SISTEMA_RAM_ARB_FIXED_PRIO_EN
        win = 0;
`else
        win = (prev_w == 0) ? 1 : 0;
`endif
      end else if (rq[0]) win = 0;
      else if (rq[1]) win = 1;

      if (win >= 0) begin
        last_a = a[win]; last_be = be[win]; last_d = wd[win];
      end
      xv0 = 1'b0; xv1 = 1'b0; xd0 = '0; xd1 = '0;
      if (retq.size() > 0) begin
        ret = retq.pop_front();
        if (ret.owner) begin xv1 = 1'b1; xd1 = ret.data; end
        else begin xv0 = 1'b1; xd0 = ret.data; end
      end

      chk_bit($sformatf("r%0d_wait0", c), m0_waitrequest, rq[0] && win != 0);
      chk_bit($sformatf("r%0d_wait1", c), m1_waitrequest, rq[1] && win != 1);
      chk_bit($sformatf("r%0d_cs", c), ram_chipselect, win >= 0);
      chk_bit($sformatf("r%0d_we", c), ram_write, (win >= 0) ? w[win] : 1'b0);
      chk_word($sformatf("r%0d_addr", c), 32'(ram_address), 32'(last_a));
      chk_word($sformatf("r%0d_be", c), 32'(ram_byteenable), 32'(last_be));
      chk_word($sformatf("r%0d_wdata", c), ram_writedata, last_d);
      chk_bit($sformatf("r%0d_rdv0", c), m0_readdatavalid, xv0);
      chk_bit($sformatf("r%0d_rdv1", c), m1_readdatavalid, xv1);
      chk_word($sformatf("r%0d_rd0", c), m0_readdata, xd0);
      chk_word($sformatf("r%0d_rd1", c), m1_readdata, xd1);

      if (win >= 0) begin
        if (w[win]) begin
          d = ref_mem[a[win]];
          for (int b = 0; b < int'(BE_W); b++)
            if (be[win][b]) d[b*8 +: 8] = wd[win][b*8 +: 8];
          ref_mem[a[win]] = d;
        end else begin
          ret.owner = (win == 1);
          ret.data  = ref_mem[a[win]];
          retq.push_back(ret);
        end
        prev_w = win;
      end
      hold[0] = rq[0] && win != 0;
      hold[1] = rq[1] && win != 1;
      @(posedge clk); #1;
    end

`ifdef SISTEMA_RAM_ARB_FIXED_PRIO_EN
    // Fixed priority: m0 streams four writes while m1 stalls throughout.
    for (int i = 0; i < 4; i++) begin
      drive(L, H, ADDR_W'(10'h100 + i), 4'hF, 32'hC0DE_0000 | 32'(i), L, H, 10'h200, 4'hF, 32'hFFFF_FFFF);
      @(negedge clk);
      chk_bit($sformatf("fp%0d_wait1", i), m1_waitrequest, H);
      chk_bit($sformatf("fp%0d_wait0", i), m0_waitrequest, L);
      @(posedge clk); #1;
    end
    idle();
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      chk_word($sformatf("fp%0d_mem", i), mem[10'h100 + i], 32'hC0DE_0000 | 32'(i));
`endif

    idle();
    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sistema_ram_arbiter.md
SISTEMA_RAM_ARBITER -- requirements
Module: sistema_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the RAM word-address width (1024 words).
REQ-002 SHALL have parameter DATA_W, default 32, meaning the data width; byteenable width SHALL be DATA_W/8.
REQ-003 SHALL run on one clock; reset is asynchronous and active-high.
REQ-004 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- mN_address  in  ADDR_W  requester N word address, N = 0, 1
- mN_byteenable  in  DATA_W/8  requester N byte lanes
- mN_read  in  1  requester N read request
- mN_write  in  1  requester N write request
- mN_writedata  in  DATA_W  requester N write data
- mN_waitrequest  out  1  high = requester N must hold its request
- mN_readdata  out  DATA_W  requester N read data
- mN_readdatavalid  out  1  requester N read data valid
- ram_address  out  ADDR_W  RAM address
- ram_byteenable  out  DATA_W/8  RAM byte enables
- ram_chipselect  out  1  RAM select
- ram_write  out  1  RAM write
- ram_writedata  out  DATA_W  RAM write data
- ram_clken  out  1  RAM clock enable, constant 1
- ram_readdata  in  DATA_W  RAM read data, valid one cycle after the address is sampled

Function
REQ-005 SHALL treat requester N as requesting when mN_read or mN_write is high.
REQ-006 SHALL grant at most one requester per cycle, combinationally from the current requests and the last_grant register.
REQ-007 SHALL drive mN_waitrequest low in the cycle requester N is granted, and high when N requests but is not granted.
REQ-008 SHALL drive mN_waitrequest low when requester N is idle.
REQ-009 With no grant, SHALL drive ram_chipselect = 0 and ram_write = 0; ram_address, ram_byteenable and ram_writedata SHALL hold the last granted values (hold register).
REQ-010 On a grant, SHALL drive the granted requester's address, byteenable and writedata to the RAM ports, with ram_chipselect = 1 and ram_write = mN_write.
REQ-011 A granted write SHALL complete in its grant cycle; no readdatavalid is generated.
REQ-012 A granted read in cycle T SHALL set the rd_pending and rd_owner registers, so that readdatavalid pulses high for the owner in cycle T+1 with readdata = ram_readdata; latency is exactly 1.
REQ-013 mN_readdata SHALL be 0 whenever mN_readdatavalid is low.
REQ-014 Back-to-back reads SHALL be supported: one grant per cycle and one readdatavalid per cycle, in issue order.
REQ-015 If mN_read and mN_write are both high, SHALL perform the write only and return no read data.
REQ-016 Round-robin arbitration:
- when both requesters request, grant the one not equal to last_grant;
- when one requests, grant it;
- last_grant SHALL update only on a granted cycle.
REQ-017 Under continuous contention, each requester SHALL be granted on alternate cycles; no requester SHALL wait more than 1 cycle.

Reset
REQ-018 Reset SHALL immediately force: last_grant = 1, rd_pending = 0, rd_owner = 0, and hold registers = 0.
REQ-019 During reset, all outputs SHALL be 0 except mN_waitrequest = 1 and ram_clken = 1.
REQ-020 Reset asserted with a read in flight SHALL discard that read; no readdatavalid SHALL be issued after reset deasserts.
REQ-021 In the first cycle after reset deasserts, a simultaneous request from both requesters SHALL grant m0.

Configuration
REQ-022 Macro SISTEMA_RAM_ARB_FIXED_PRIO_EN, when defined:
- arbitration SHALL be fixed priority, m0 always beating m1;
- last_grant SHALL not exist;
- REQ-017 SHALL not apply.
When undefined, round-robin per REQ-016 SHALL apply.

Verification
REQ-023 m0 writes 0xDEADBEEF to address 0x005 with byteenable 0xF, then reads 0x005 -> write has waitrequest 0; read returns readdatavalid one cycle after grant with readdata 0xDEADBEEF.
REQ-024 m0 and m1 both read continuously (m0 from 0x010, m1 from 0x020) after reset -> grants alternate m0, m1, m0...; each readdatavalid goes to the correct owner with the correct data.
REQ-025 m1 writes 0x11223344 to 0x3FF with byteenable 0x3, over prior contents 0xAAAAAAAA -> a later read returns 0xAAAA3344.
REQ-026 m0 read granted, then reset asserted before the next clock edge -> m0_readdatavalid stays 0 through reset and after release.
REQ-027 With the macro defined, m0 and m1 both write continuously for 4 cycles -> m1_waitrequest stays 1 for all 4 cycles and all 4 m0 writes land.
REQ-028 m0 asserts read and write together to 0x001 with writedata 0x5A5A5A5A -> RAM is written, and no readdatavalid is issued.
